// File: rtl/fft_pkg.sv
// Shared FFT definitions: sequencer state encoding and the ictrl tag bit positions
// that travel with each butterfly pair through the datapath.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        NEXT  = 3'd4,
        FIN   = 3'd5
    } seq_state_t;

    localparam int CTRL_FIRST = 0;
    localparam int CTRL_LAST  = 1;

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Issue/retire bundle between the stage sequencer (master) and the
// butterflyCore / RAM / twiddle-ROM datapath (slave).
interface fft_stage_sequencer_if #(
    parameter int FFT_N             = 10,
    parameter int FFT_MAX_BIT_WIDTH = 5,
    parameter int SW                = 4
) ();

    logic                         issue_rdy;
    logic                         iact;
    logic [1:0]                   ictrl;
    logic [FFT_N-2:0]             pair_idx;
    logic [FFT_N-1:0]             addr_a;
    logic [FFT_N-1:0]             addr_b;
    logic [FFT_N-2:0]             tw_addr;
    logic [SW-1:0]                stage;
    logic                         clr_bfp;
    logic [FFT_MAX_BIT_WIDTH-1:0] ibfp;
    logic                         oact;
    logic [1:0]                   octrl;
    logic [FFT_MAX_BIT_WIDTH-1:0] max_bw;

    modport master (
        input  issue_rdy, oact, octrl, max_bw,
        output iact, ictrl, pair_idx, addr_a, addr_b, tw_addr, stage, clr_bfp, ibfp
    );

    modport slave (
        output issue_rdy, oact, octrl, max_bw,
        input  iact, ictrl, pair_idx, addr_a, addr_b, tw_addr, stage, clr_bfp, ibfp
    );

endinterface

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT in-place addressing: pair index p and stage s give both operand
// addresses and the twiddle ROM index. Purely combinational.
module fft_addr_gen #(
    parameter int FFT_N = 10,
    parameter int SW    = 4
) (
    input  logic [FFT_N-2:0] p,
    input  logic [SW-1:0]    s,
    output logic [FFT_N-1:0] addr_a,
    output logic [FFT_N-1:0] addr_b,
    output logic [FFT_N-2:0] tw_addr
);

    localparam logic [FFT_N-1:0] ONE    = {{(FFT_N-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]    TW_TOP = SW'(FFT_N - 1);

    logic [FFT_N-1:0] p_ext_s;
    logic [FFT_N-1:0] h_s;
    logic [FFT_N-1:0] low_s;
    logic [SW-1:0]    tw_sh_s;

    // Split p at bit s and insert a zero there; B is A with that bit set.
    always_comb begin
        p_ext_s = {1'b0, p};
        h_s     = ONE << s;
        low_s   = p_ext_s & (h_s - ONE);
        addr_a  = ((p_ext_s & ~low_s) << 1) | low_s;
        addr_b  = addr_a | h_s;
        tw_sh_s = TW_TOP - s;
        tw_addr = low_s[FFT_N-2:0] << tw_sh_s;
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Drives the butterflyCore through every radix-2 stage of a 2^FFT_N-point FFT,
// counting retirements and carrying the block-floating-point width between stages.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int FFT_N             = 10,
    parameter int FFT_MAX_BIT_WIDTH = 5,
    parameter int SW                = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    fft_stage_sequencer_if.master bus
);

    localparam int                PW      = FFT_N - 1;
    localparam logic [PW-1:0]     P_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0]     P_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]     P_LAST  = {PW{1'b1}};
    localparam logic [FFT_N-1:0]  RC_ONE  = {{(FFT_N-1){1'b0}}, 1'b1};
    localparam logic [FFT_N-1:0]  RC_FULL = {1'b1, {PW{1'b0}}};
    localparam logic [FFT_N-1:0]  RC_LAST = {1'b0, {PW{1'b1}}};
    localparam logic [SW-1:0]     S_ONE   = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]     S_LAST  = SW'(FFT_N - 1);

    seq_state_t                   state_r;
    seq_state_t                   state_nxt_s;
    logic [SW-1:0]                stage_r;
    logic [PW-1:0]                p_r;
    logic [PW-1:0]                p_nxt_s;
    logic [FFT_N-1:0]             rc_r;
    logic [FFT_MAX_BIT_WIDTH-1:0] bw_max_r;
    logic [FFT_MAX_BIT_WIDTH-1:0] ibfp_r;
    logic                         err_r;
    logic                         busy_r;
    logic                         done_r;
    logic                         clr_r;
    logic [FFT_N-1:0]             addr_a_r;
    logic [FFT_N-1:0]             addr_b_r;
    logic [PW-1:0]                tw_r;
    logic [1:0]                   ictrl_r;
    logic [FFT_N-1:0]             addr_a_s;
    logic [FFT_N-1:0]             addr_b_s;
    logic [PW-1:0]                tw_s;
    logic [1:0]                   ictrl_s;
    logic                         issue_s;
    logic                         last_issue_s;
    logic                         rc_full_s;
    logic                         ret_ok_s;
    logic                         ret_err_s;
    logic                         addr_load_s;

    // Addresses are computed for the pair presented next cycle, so they line up with iact.
    fft_addr_gen #(
        .FFT_N (FFT_N),
        .SW    (SW)
    ) u_addr_gen (
        .p       (p_nxt_s),
        .s       (stage_r),
        .addr_a  (addr_a_s),
        .addr_b  (addr_b_s),
        .tw_addr (tw_s)
    );

    // Issue/retire qualification and the next pair index.
    always_comb begin
        issue_s      = (state_r == ISSUE) && bus.issue_rdy;
        last_issue_s = issue_s && (p_r == P_LAST);
        rc_full_s    = (rc_r == RC_FULL);
        ret_ok_s     = bus.oact && (state_r != IDLE) && !rc_full_s;
        ret_err_s    = bus.oact && ((state_r == IDLE) || rc_full_s ||
                                    (bus.octrl[CTRL_LAST] && (rc_r != RC_LAST)));
        addr_load_s  = (state_r == CLR) || issue_s;
        if (state_r == CLR) begin
            p_nxt_s = P_ZERO;
        end else if (issue_s && !last_issue_s) begin
            p_nxt_s = p_r + P_ONE;
        end else begin
            p_nxt_s = p_r;
        end
        ictrl_s             = 2'b00;
        ictrl_s[CTRL_FIRST] = (p_nxt_s == P_ZERO);
        ictrl_s[CTRL_LAST]  = (p_nxt_s == P_LAST);
    end

    // Stage sequencing FSM: next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (start) state_nxt_s = CLR; else state_nxt_s = IDLE;
            CLR:     state_nxt_s = ISSUE;
            ISSUE:   if (last_issue_s) state_nxt_s = DRAIN; else state_nxt_s = ISSUE;
            DRAIN:   if (rc_full_s) state_nxt_s = NEXT; else state_nxt_s = DRAIN;
            NEXT:    if (stage_r == S_LAST) state_nxt_s = FIN; else state_nxt_s = CLR;
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stage, pair and retire bookkeeping plus the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_r  <= {SW{1'b0}};
            p_r      <= P_ZERO;
            rc_r     <= {FFT_N{1'b0}};
            bw_max_r <= {FFT_MAX_BIT_WIDTH{1'b0}};
            ibfp_r   <= {FFT_MAX_BIT_WIDTH{1'b0}};
            err_r    <= 1'b0;
        end else begin
            p_r <= p_nxt_s;
            if ((state_r == IDLE) && start) begin
                stage_r <= {SW{1'b0}};
                ibfp_r  <= {FFT_MAX_BIT_WIDTH{1'b0}};
            end else if (state_r == NEXT) begin
                ibfp_r <= bw_max_r;
                if (stage_r != S_LAST) stage_r <= stage_r + S_ONE;
                else                   stage_r <= stage_r;
            end else begin
                stage_r <= stage_r;
                ibfp_r  <= ibfp_r;
            end
            // CLR wins over a same-cycle retire: that retire already belongs to the old stage.
            if (state_r == CLR) begin
                rc_r     <= {FFT_N{1'b0}};
                bw_max_r <= {FFT_MAX_BIT_WIDTH{1'b0}};
            end else if (ret_ok_s) begin
                rc_r <= rc_r + RC_ONE;
                if (bus.max_bw > bw_max_r) bw_max_r <= bus.max_bw;
                else                       bw_max_r <= bw_max_r;
            end else begin
                rc_r     <= rc_r;
                bw_max_r <= bw_max_r;
            end
            if (ret_err_s)                      err_r <= 1'b1;
            else if ((state_r == IDLE) && start) err_r <= 1'b0;
            else                                 err_r <= err_r;
        end
    end

    // Registered status pulses and the issue-aligned address/tag outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            clr_r    <= 1'b0;
            addr_a_r <= {FFT_N{1'b0}};
            addr_b_r <= {FFT_N{1'b0}};
            tw_r     <= P_ZERO;
            ictrl_r  <= 2'b00;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            done_r <= (state_nxt_s == FIN);
            clr_r  <= (state_nxt_s == CLR);
            if (addr_load_s) begin
                addr_a_r <= addr_a_s;
                addr_b_r <= addr_b_s;
                tw_r     <= tw_s;
                ictrl_r  <= ictrl_s;
            end else begin
                addr_a_r <= addr_a_r;
                addr_b_r <= addr_b_r;
                tw_r     <= tw_r;
                ictrl_r  <= ictrl_r;
            end
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign bus.iact     = issue_s;
    assign bus.ictrl    = ictrl_r;
    assign bus.pair_idx = p_r;
    assign bus.addr_a   = addr_a_r;
    assign bus.addr_b   = addr_b_r;
    assign bus.tw_addr  = tw_r;
    assign bus.stage    = stage_r;
    assign bus.clr_bfp  = clr_r;
    assign bus.ibfp     = ibfp_r;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer with a fixed-latency butterfly model.
module tb_fft_stage_sequencer;

    localparam int N   = 4;
    localparam int PW  = N - 1;
    localparam int MBW = 5;
    localparam int SW  = 4;
    localparam int P   = 8;
    localparam int LAT = 6;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic err;

    fft_stage_sequencer_if #(.FFT_N(N), .FFT_MAX_BIT_WIDTH(MBW), .SW(SW)) bus ();

    fft_stage_sequencer #(.FFT_N(N), .FFT_MAX_BIT_WIDTH(MBW), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [PW-1:0]  tw;
        logic [PW-1:0]  p;
        logic [1:0]     ictrl;
        logic [SW-1:0]  s;
        logic [MBW-1:0] ibfp;
        logic [MBW-1:0] bw;
        bit             bad_ctrl;
        bit             extra;
    } exp_t;

    typedef struct {
        int             due;
        logic [1:0]     octrl;
        logic [MBW-1:0] bw;
        bit             extra;
    } ret_t;

    exp_t exp_q[$];
    ret_t ret_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   done_cnt = 0;
    int   clr_cnt = 0;
    int   done_cyc = 0;
    int   last_ret_cyc = 0;
    bit   seen_trig = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},     64'(busy), 64'd0);
        check({tag, "_done"},     64'(done), 64'd0);
        check({tag, "_err"},      64'(err), 64'd0);
        check({tag, "_iact"},     64'(bus.iact), 64'd0);
        check({tag, "_ictrl"},    64'(bus.ictrl), 64'd0);
        check({tag, "_pair_idx"}, 64'(bus.pair_idx), 64'd0);
        check({tag, "_addr_a"},   64'(bus.addr_a), 64'd0);
        check({tag, "_addr_b"},   64'(bus.addr_b), 64'd0);
        check({tag, "_tw_addr"},  64'(bus.tw_addr), 64'd0);
        check({tag, "_stage"},    64'(bus.stage), 64'd0);
        check({tag, "_clr_bfp"},  64'(bus.clr_bfp), 64'd0);
        check({tag, "_ibfp"},     64'(bus.ibfp), 64'd0);
    endtask

    // Stimulus driver: issue_rdy pattern and butterfly retirements, driven just after each rising edge.
    initial begin
        ret_t r;
        bit   extra_pend;
        extra_pend    = 1'b0;
        bus.issue_rdy = 1'b0;
        bus.oact      = 1'b0;
        bus.octrl     = 2'b00;
        bus.max_bw    = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                1:       bus.issue_rdy = 1'(cyc % 2);
                2:       bus.issue_rdy = 1'($urandom_range(0, 1));
                default: bus.issue_rdy = 1'b1;
            endcase
            bus.oact   = 1'b0;
            bus.octrl  = 2'b00;
            bus.max_bw = '0;
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                r          = ret_q.pop_front();
                bus.oact   = 1'b1;
                bus.octrl  = r.octrl;
                bus.max_bw = r.bw;
                if (r.extra) extra_pend = 1'b1;
            end else if (extra_pend) begin
                bus.oact   = 1'b1;
                bus.octrl  = 2'b00;
                bus.max_bw = '1;
                extra_pend = 1'b0;
            end
        end
    end

    // Monitor: compare each issued pair against the scoreboard and hand it to the butterfly model.
    always @(negedge clk) begin
        exp_t e;
        ret_t r;
        if (bus.clr_bfp) clr_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.oact) last_ret_cyc = cyc;
        if (bus.iact) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got stage %0d pair %0d want none", bus.stage, bus.pair_idx);
            end else begin
                e = exp_q.pop_front();
                check("addr_a",   64'(bus.addr_a), 64'(e.a));
                check("addr_b",   64'(bus.addr_b), 64'(e.b));
                check("tw_addr",  64'(bus.tw_addr), 64'(e.tw));
                check("pair_idx", 64'(bus.pair_idx), 64'(e.p));
                check("ictrl",    64'(bus.ictrl), 64'(e.ictrl));
                check("stage",    64'(bus.stage), 64'(e.s));
                check("ibfp",     64'(bus.ibfp), 64'(e.ibfp));
                if (bus.stage == 4'd2 && bus.pair_idx == 3'd4) seen_trig = 1'b1;
                r.due   = cyc + LAT;
                r.octrl = e.bad_ctrl ? 2'b10 : bus.ictrl;
                r.bw    = e.bw;
                r.extra = e.extra;
                ret_q.push_back(r);
            end
        end
    end

    // Reference model: every pair of every stage from plain arithmetic, then a start pulse.
    task automatic run_fft(input int mode, input bit fix0, input bit inj_extra,
                           input bit inj_ctrl, input bit wait_done);
        int   tab0 [P] = '{3, 7, 2, 5, 1, 4, 6, 0};
        int   prevmax = 0;
        int   curmax;
        int   h;
        int   bw;
        int   base;
        int   k;
        exp_t e;
        for (int s = 0; s < N; s++) begin
            curmax = 0;
            h      = 1 << s;
            for (int p = 0; p < P; p++) begin
                base       = (p / h) * 2 * h + (p % h);
                e.a        = N'(base);
                e.b        = N'(base + h);
                e.tw       = PW'((p % h) * (P / h));
                e.p        = PW'(p);
                e.s        = SW'(s);
                e.ictrl    = {p == P - 1, p == 0};
                e.ibfp     = MBW'(prevmax);
                bw         = (fix0 && s == 0) ? tab0[p] : int'($urandom_range(0, 30));
                e.bw       = MBW'(bw);
                e.bad_ctrl = inj_ctrl && s == 0 && p == 2;
                e.extra    = inj_extra && s == 1 && p == P - 1;
                if (bw > curmax) curmax = bw;
                exp_q.push_back(e);
            end
            prevmax = curmax;
        end
        rdy_mode = mode;
        done_cnt = 0;
        clr_cnt  = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
        check("err_cleared_by_start", 64'(err), 64'd0);
        if (wait_done) begin
            k = 0;
            while (done_cnt == 0 && k < 3000) begin
                @(negedge clk);
                k++;
            end
            if (done_cnt == 0) begin
                total++;
                bad++;
                $display("FAIL done_timeout: got no done want done within 3000 cycles");
            end
            repeat (4) @(negedge clk);
            check("done_once", 64'(done_cnt), 64'd1);
            check("clr_pulses", 64'(clr_cnt), 64'(N));
            check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
            check("done_latency", 64'(done_cyc - last_ret_cyc), 64'd3);
            check("busy_after_done", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int k;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        run_fft(0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("err_clean_run", 64'(err), 64'd0);
        run_fft(1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("err_toggle_run", 64'(err), 64'd0);
        run_fft(2, 1'b0, 1'b0, 1'b0, 1'b1);
        check("err_random_run", 64'(err), 64'd0);

        run_fft(0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("err_extra_oact", 64'(err), 64'd1);
        repeat (5) @(negedge clk);
        check("err_sticky", 64'(err), 64'd1);
        run_fft(2, 1'b0, 1'b0, 1'b1, 1'b1);
        check("err_octrl_last", 64'(err), 64'd1);

        seen_trig = 1'b0;
        run_fft(0, 1'b0, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (!seen_trig && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!seen_trig) begin
            total++;
            bad++;
            $display("FAIL stage2_timeout: got no stage-2 issue want one within 2000 cycles");
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_zero("midrun_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        k = 0;
        while (ret_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("err_spurious_after_reset", 64'(err), 64'd1);
        check("done_not_after_reset", 64'(done_cnt), 64'd0);
        run_fft(0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("err_after_recovery", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
